// File: rtl/prg_rom_loader.sv
// Boot loader: parses an iNES header, then streams a 16 KB NROM PRG image into ROM.
// Optional macro PRG_LOADER_CHR_EN adds a CHR write port; otherwise CHR bytes are discarded.
module prg_rom_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        mirror_v,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
`ifdef PRG_LOADER_CHR_EN
  ,
  output logic        chr_wr_en,
  output logic [12:0] chr_wr_addr,
  output logic [7:0]  chr_wr_data
`endif
);

  typedef enum logic [2:0] {
    S_HDR, S_TRN, S_PRG, S_CHR, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  hcnt;
  logic [8:0]  tcnt;
  logic [13:0] pcnt;
  logic [12:0] ccnt;
  logic        trainer;
  logic        chr_present;
  logic        hdr_ok;
  logic        accept;

  assign in_ready = (state != S_DONE) && (state != S_ERR);
  assign accept   = in_valid && in_ready;
  assign error    = (state == S_ERR);
  assign cpu_hold = ~done;

  // Header byte validation: magic, one PRG bank, at most one CHR bank, mapper 0.
  always_comb begin
    hdr_ok = 1'b1;
    case (hcnt)
      4'd0:    hdr_ok = (in_data == 8'h4E);
      4'd1:    hdr_ok = (in_data == 8'h45);
      4'd2:    hdr_ok = (in_data == 8'h53);
      4'd3:    hdr_ok = (in_data == 8'h1A);
      4'd4:    hdr_ok = (in_data == 8'h01);
      4'd5:    hdr_ok = (in_data <= 8'h01);
      4'd6:    hdr_ok = (in_data[7:4] == 4'h0);
      4'd7:    hdr_ok = (in_data[7:4] == 4'h0);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR: begin
        if (accept) begin
          if (!hdr_ok)
            state_nx = S_ERR;
          else if (hcnt == 4'd15)
            state_nx = trainer ? S_TRN : S_PRG;
        end
      end
      S_TRN: if (accept && tcnt == 9'd511) state_nx = S_PRG;
      S_PRG: if (accept && pcnt == 14'h3FFF) state_nx = chr_present ? S_CHR : S_DONE;
      S_CHR: if (accept && ccnt == 13'h1FFF) state_nx = S_DONE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HDR;
      hcnt        <= '0;
      tcnt        <= '0;
      pcnt        <= '0;
      ccnt        <= '0;
      trainer     <= 1'b0;
      chr_present <= 1'b0;
      mirror_v    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == S_DONE);
      wr_en <= accept && (state == S_PRG);
      if (accept) begin
        case (state)
          S_HDR: begin
            hcnt <= hcnt + 4'd1;
            if (hcnt == 4'd5) chr_present <= in_data[0];
            if (hcnt == 4'd6) begin
              mirror_v <= in_data[0];
              trainer  <= in_data[2];
            end
          end
          S_TRN: tcnt <= tcnt + 9'd1;
          S_PRG: begin
            pcnt    <= pcnt + 14'd1;
            wr_addr <= pcnt;
            wr_data <= in_data;
          end
          S_CHR: ccnt <= ccnt + 13'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef PRG_LOADER_CHR_EN
  // CHR writes mirror the PRG port timing, addressed by the CHR byte count.
  always_ff @(posedge clk) begin
    if (rst) begin
      chr_wr_en   <= 1'b0;
      chr_wr_addr <= '0;
      chr_wr_data <= '0;
    end else begin
      chr_wr_en <= accept && (state == S_CHR);
      if (accept && state == S_CHR) begin
        chr_wr_addr <= ccnt;
        chr_wr_data <= in_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prg_rom_loader.sv
// Self-checking bench for prg_rom_loader: random images and in_valid duty checked
// against a stream-position model of the loader.
module tb_prg_rom_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mirror_v;
  logic        done;
  logic        error;
  logic        cpu_hold;
`ifdef PRG_LOADER_CHR_EN
  logic        chr_wr_en;
  logic [12:0] chr_wr_addr;
  logic [7:0]  chr_wr_data;
`endif

  prg_rom_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mirror_v (mirror_v),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
`ifdef PRG_LOADER_CHR_EN
    ,
    .chr_wr_en   (chr_wr_en),
    .chr_wr_addr (chr_wr_addr),
    .chr_wr_data (chr_wr_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] hdr [16];
  logic [7:0] img [$];
  int nwrites;
  int nchr;
  int first_wr_idx;

  task automatic set_hdr(input logic [7:0] b4, input logic [7:0] b5,
                         input logic [7:0] b6, input logic [7:0] b7);
    hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
    hdr[4] = b4;    hdr[5] = b5;    hdr[6] = b6;    hdr[7] = b7;
    for (int i = 8; i < 16; i++) hdr[i] = 8'($urandom);
  endtask

  // Stream = header, optional 512-byte trainer, 16 KB PRG, optional 8 KB CHR.
  task automatic build_image(input bit pattern);
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(hdr[i]);
    if (hdr[6][2]) for (int i = 0; i < 512; i++) img.push_back(8'($urandom));
    for (int i = 0; i < 16384; i++)
      img.push_back(pattern ? 8'((i & 255) ^ 8'hA5) : 8'($urandom));
    if (hdr[5] == 8'd1) for (int i = 0; i < 8192; i++) img.push_back(8'($urandom));
  endtask

  // Index of the first header byte that breaks the iNES/NROM rules, or -1.
  function automatic int header_err();
    logic [7:0] magic [4];
    magic[0] = 8'h4E; magic[1] = 8'h45; magic[2] = 8'h53; magic[3] = 8'h1A;
    for (int i = 0; i < 4; i++) if (hdr[i] != magic[i]) return i;
    if (hdr[4] != 8'd1) return 4;
    if (hdr[5] > 8'd1) return 5;
    if (hdr[6][7:4] != 4'h0) return 6;
    if (hdr[7][7:4] != 4'h0) return 7;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives img with the given valid duty (percent) and checks every cycle against
  // the position in the stream. stop_after >= 0 abandons the image after that many bytes.
  task automatic drive_image(input int duty, input int stop_after);
    int erri, prg0, chr0, total, lim, idx, pidx, since;
    bit v, acc, exp_wr, exp_done, exp_err, exp_m;
`ifdef PRG_LOADER_CHR_EN
    bit exp_cw;
`endif
    erri  = header_err();
    prg0  = 16 + (hdr[6][2] ? 512 : 0);
    chr0  = prg0 + 16384;
    total = chr0 + ((hdr[5] == 8'd1) ? 8192 : 0);
    lim   = (erri >= 0) ? erri + 1 : total;
    idx = 0; since = 0;
    nwrites = 0; nchr = 0; first_wr_idx = -1;
    forever begin
      checks++;
      if (in_ready !== (idx < lim)) begin
        errors++;
        $display("FAIL in_ready idx=%0d got %b exp %b", idx, in_ready, idx < lim);
      end
      if (stop_after >= 0 && idx == stop_after) break;
      if (idx == lim && since >= 4) break;
      v = ($urandom_range(99) < duty);
      in_valid = v;
      in_data  = (idx < img.size()) ? img[idx] : 8'($urandom);
      acc  = v && (idx < lim);
      pidx = idx;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        since = 0;
      end else if (idx == lim) begin
        since++;
      end

      exp_wr = acc && erri < 0 && pidx >= prg0 && pidx < chr0;
      checks++;
      if (wr_en !== exp_wr) begin
        errors++;
        $display("FAIL wr_en pos=%0d got %b exp %b", pidx, wr_en, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (wr_addr !== 14'(pidx - prg0) || wr_data !== img[pidx]) begin
          errors++;
          $display("FAIL wr_addr/data pos=%0d got %h/%h exp %h/%h", pidx, wr_addr, wr_data,
                   14'(pidx - prg0), img[pidx]);
        end
      end
      if (wr_en === 1'b1) begin
        nwrites++;
        if (first_wr_idx < 0) first_wr_idx = pidx;
      end

      exp_err  = (erri >= 0) && (idx == lim);
      exp_done = (erri < 0) && (idx == lim) && (since >= 1);
      checks++;
      if (error !== exp_err || done !== exp_done || cpu_hold !== !exp_done) begin
        errors++;
        $display("FAIL status pos=%0d got err=%b done=%b hold=%b exp err=%b done=%b hold=%b",
                 pidx, error, done, cpu_hold, exp_err, exp_done, !exp_done);
      end

      if (erri != 6) begin
        exp_m = (idx > 6) ? img[6][0] : 1'b0;
        checks++;
        if (mirror_v !== exp_m) begin
          errors++;
          $display("FAIL mirror_v pos=%0d got %b exp %b", pidx, mirror_v, exp_m);
        end
      end

`ifdef PRG_LOADER_CHR_EN
      exp_cw = acc && erri < 0 && pidx >= chr0;
      checks++;
      if (chr_wr_en !== exp_cw) begin
        errors++;
        $display("FAIL chr_wr_en pos=%0d got %b exp %b", pidx, chr_wr_en, exp_cw);
      end
      if (exp_cw) begin
        checks++;
        if (chr_wr_addr !== 13'(pidx - chr0) || chr_wr_data !== img[pidx]) begin
          errors++;
          $display("FAIL chr_wr_addr/data pos=%0d got %h/%h exp %h/%h", pidx, chr_wr_addr,
                   chr_wr_data, 13'(pidx - chr0), img[pidx]);
        end
      end
      if (chr_wr_en === 1'b1) nchr++;
`endif
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 14'd0 || wr_data !== 8'd0 ||
        mirror_v !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s got rdy=%b we=%b a=%h d=%h m=%b done=%b err=%b hold=%b exp 1 0 0 0 0 0 0 1",
               tag, in_ready, wr_en, wr_addr, wr_data, mirror_v, done, error, cpu_hold);
    end
`ifdef PRG_LOADER_CHR_EN
    checks++;
    if (chr_wr_en !== 1'b0 || chr_wr_addr !== 13'd0 || chr_wr_data !== 8'd0) begin
      errors++;
      $display("FAIL %s chr port got %b %h %h exp 0 0 0", tag, chr_wr_en, chr_wr_addr, chr_wr_data);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h4E;
    @(posedge clk); #1;
    check_reset_outputs("reset_values");
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    do_reset();
    set_hdr(8'd1, 8'd0, 8'h01, 8'h00);
    build_image(1'b1);
    drive_image(100, -1);
    checks++;
    if (nwrites !== 16384 || mirror_v !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_load_end got writes=%0d m=%b done=%b rdy=%b exp 16384 1 1 0",
               nwrites, mirror_v, done, in_ready);
    end
  endtask

  task automatic test_header_errors();
    for (int k = 0; k < 5; k++) begin
      do_reset();
      set_hdr(8'd1, 8'd0, 8'h00, 8'h00);
      case (k)
        0: hdr[3] = 8'h1B;
        1: hdr[6] = 8'h10;
        2: hdr[4] = 8'd2;
        3: hdr[5] = 8'd2;
        default: hdr[7] = 8'h20;
      endcase
      build_image(1'b0);
      drive_image(100, -1);
      checks++;
      if (nwrites !== 0 || error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL header_error case=%0d got writes=%0d err=%b done=%b rdy=%b exp 0 1 0 0",
                 k, nwrites, error, done, in_ready);
      end
    end
  endtask

  task automatic test_trainer_random_duty();
    do_reset();
    set_hdr(8'd1, 8'd0, {5'b0, 1'b1, 1'b0, 1'($urandom)}, 8'h00);
    build_image(1'b0);
    drive_image(40, -1);
    checks++;
    if (nwrites !== 16384 || first_wr_idx !== 528 || done !== 1'b1) begin
      errors++;
      $display("FAIL trainer_load got writes=%0d first=%0d done=%b exp 16384 528 1",
               nwrites, first_wr_idx, done);
    end
  endtask

  task automatic test_reset_midload_chr();
    do_reset();
    set_hdr(8'd1, 8'd0, 8'h01, 8'h00);
    build_image(1'b0);
    drive_image(100, 116);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midload_reset");
    rst = 1'b0;
    set_hdr(8'd1, 8'd1, 8'h00, 8'h00);
    build_image(1'b0);
    drive_image(100, -1);
    checks++;
    if (nwrites !== 16384 || first_wr_idx !== 16 || done !== 1'b1) begin
      errors++;
      $display("FAIL reload got writes=%0d first=%0d done=%b exp 16384 16 1",
               nwrites, first_wr_idx, done);
    end
`ifdef PRG_LOADER_CHR_EN
    checks++;
    if (nchr !== 8192) begin
      errors++;
      $display("FAIL chr_count got %0d exp 8192", nchr);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_full_load();
    test_header_errors();
    test_trainer_random_duty();
    test_reset_midload_chr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
